// File: rtl/mem_responder_pkg.sv
// Shared types and constants for the two-lane memory responder.
// Holds the latched request, the per-lane result and the FSM state type.
package mem_responder_pkg;

   localparam int unsigned MEM_LANES        = 2;
   localparam logic [31:0] MEM_TIMEOUT_DATA = 32'hDEAD_BEEF;

   // addr holds the word address; byte-offset bits are dropped at latch time
   typedef struct packed {
      logic        valid;
      logic        we;
      logic [29:0] addr;
      logic [31:0] wdata;
      logic [3:0]  be;
   } MEM_PORT_REQ;

   typedef struct packed {
      logic [31:0] rdata;
      logic        err;
   } MEM_PORT_RESP;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ACC0 = 2'd1,
      ACC1 = 2'd2,
      RESP = 2'd3
   } MEM_RESP_STATE;

   function automatic logic [3:0] mem_strobe(input MEM_PORT_REQ r);
      return r.we ? r.be : 4'b0000;
   endfunction

endpackage

// File: rtl/mem_responder_if.sv
// Bundle between the memory pipeline stage, the responder and the SRAM.
// slave is the responder's view; master is the pipeline-plus-SRAM side.
interface mem_responder_if;
   import mem_responder_pkg::*;

   logic [MEM_LANES-1:0]       req_valid;
   logic [MEM_LANES-1:0]       req_we;
   logic [MEM_LANES-1:0][31:0] req_addr;
   logic [MEM_LANES-1:0][31:0] req_wdata;
   logic [MEM_LANES-1:0][3:0]  req_be;

   logic                       stall;
   logic                       resp_valid;
   logic [MEM_LANES-1:0][31:0] resp_rdata;
   logic [MEM_LANES-1:0]       resp_err;

   logic                       sram_req;
   logic [3:0]                 sram_we;
   logic [29:0]                sram_addr;
   logic [31:0]                sram_wdata;
   logic                       sram_ack;
   logic [31:0]                sram_rdata;

   modport slave (
      input  req_valid, req_we, req_addr, req_wdata, req_be, sram_ack, sram_rdata,
      output stall, resp_valid, resp_rdata, resp_err, sram_req, sram_we, sram_addr, sram_wdata
   );

   modport master (
      output req_valid, req_we, req_addr, req_wdata, req_be, sram_ack, sram_rdata,
      input  stall, resp_valid, resp_rdata, resp_err, sram_req, sram_we, sram_addr, sram_wdata
   );

endinterface

// File: rtl/mem_timeout.sv
// Clearable wait counter for one SRAM access; flags expiry once the count
// reaches TIMEOUT.
module mem_timeout #(
   parameter int unsigned TIMEOUT = 255
) (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_clr,
   input  logic i_inc,
   output logic o_expired
);

   localparam int unsigned   CW    = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
   localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT);

   logic [CW-1:0] r_cnt;

   // Holds at LIMIT so a stuck increment can never wrap past expiry
   always_ff @(posedge i_clk) begin
      if (i_rst || i_clr) begin
         r_cnt <= '0;
      end else if (i_inc && !o_expired) begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

   assign o_expired = (r_cnt == LIMIT);

endmodule

// File: rtl/mem_responder.sv
// Serialises a two-lane memory-stage batch onto one SRAM port, lane 0 first,
// stalling the pipeline until a single-cycle response carries both results.
module mem_responder
   import mem_responder_pkg::*;
#(
   parameter int unsigned TIMEOUT = 255,
   parameter int unsigned LANES   = 2
) (
   input  logic           i_clk,
   input  logic           i_rst,
   mem_responder_if.slave io_bus
);

   MEM_RESP_STATE r_state;
   MEM_RESP_STATE w_state_next;
   MEM_PORT_REQ   r_req  [LANES];
   MEM_PORT_RESP  r_resp [LANES];

   MEM_PORT_REQ   w_cur;
   logic          w_lane;
   logic          w_in_acc;
   logic          w_accept;
   logic          w_expired;
   logic          w_done;
   logic          w_unused;

   assign w_in_acc = (r_state == ACC0) || (r_state == ACC1);
   assign w_lane   = (r_state == ACC1);
   assign w_cur    = r_req[w_lane];
   assign w_accept = (r_state == IDLE) && (|io_bus.req_valid) && !i_rst;
   assign w_done   = w_in_acc && (io_bus.sram_ack || w_expired);

   // Byte-offset bits never reach the SRAM
   assign w_unused = ^{io_bus.req_addr[0][1:0], io_bus.req_addr[1][1:0]};

   mem_timeout #(
      .TIMEOUT (TIMEOUT)
   ) u_timeout (
      .i_clk     (i_clk),
      .i_rst     (i_rst),
      .i_clr     (!w_in_acc || w_done),
      .i_inc     (w_in_acc && !io_bus.sram_ack),
      .o_expired (w_expired)
   );

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         IDLE:    if (w_accept) w_state_next = io_bus.req_valid[0] ? ACC0 : ACC1;
         ACC0:    if (w_done) w_state_next = r_req[1].valid ? ACC1 : RESP;
         ACC1:    if (w_done) w_state_next = RESP;
         RESP:    w_state_next = IDLE;
         default: w_state_next = IDLE;
      endcase
   end

   always_comb begin
      io_bus.stall      = 1'b0;
      io_bus.resp_valid = 1'b0;
      io_bus.sram_req   = 1'b0;
      io_bus.sram_we    = 4'b0000;
      io_bus.sram_addr  = '0;
      io_bus.sram_wdata = '0;
      case (r_state)
         IDLE: io_bus.stall = w_accept;
         ACC0, ACC1: begin
            io_bus.stall      = 1'b1;
            io_bus.sram_req   = w_cur.valid;
            io_bus.sram_we    = mem_strobe(w_cur);
            io_bus.sram_addr  = w_cur.addr;
            io_bus.sram_wdata = w_cur.wdata;
         end
         RESP:    io_bus.resp_valid = 1'b1;
         default: io_bus.stall = 1'b0;
      endcase
   end

   // Results are cleared on acceptance so write and invalid lanes read back zero
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         for (int i = 0; i < LANES; i++) begin
            r_req[i]  <= '0;
            r_resp[i] <= '0;
         end
      end else if (w_accept) begin
         for (int i = 0; i < LANES; i++) begin
            r_req[i].valid <= io_bus.req_valid[i];
            r_req[i].we    <= io_bus.req_we[i];
            r_req[i].addr  <= io_bus.req_addr[i][31:2];
            r_req[i].wdata <= io_bus.req_wdata[i];
            r_req[i].be    <= io_bus.req_be[i];
            r_resp[i]      <= '0;
         end
      end else if (w_done) begin
         if (!io_bus.sram_ack) begin
            r_resp[w_lane].rdata <= MEM_TIMEOUT_DATA;
            r_resp[w_lane].err   <= 1'b1;
         end else if (!w_cur.we) begin
            r_resp[w_lane].rdata <= io_bus.sram_rdata;
         end
      end
   end

   for (genvar g = 0; g < LANES; g++) begin : g_resp
      assign io_bus.resp_rdata[g] = r_resp[g].rdata;
      assign io_bus.resp_err[g]   = r_resp[g].err;
   end

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench for mem_responder: table-driven batches scored against a
// queue, plus hand-written reset, back-to-back and timeout sequences.
module tb_mem_responder;

   typedef struct {
      logic [1:0]  valid;
      logic [1:0]  we;
      logic [31:0] addr0;
      logic [31:0] addr1;
      logic [31:0] wdata0;
      logic [31:0] wdata1;
      logic [3:0]  be0;
      logic [3:0]  be1;
      int          delay;
      logic [31:0] exp_r0;
      logic [31:0] exp_r1;
      logic [1:0]  exp_err;
   } vec_t;

   typedef struct {
      logic [31:0] r0;
      logic [31:0] r1;
      logic [1:0]  err;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic mem_load = 1'b1;

   int n_checks = 0;
   int n_errors = 0;
   int resp_pulses = 0;
   int ack_delay = 0;
   int r_wait = 0;

   logic [31:0] mem [256];
   exp_t        sb_q [$];
   logic [33:0] acc_q [$];
   vec_t        vecs [8];

   mem_responder_if bus ();
   mem_responder_if bus2 ();

   mem_responder u_dut (
      .i_clk  (clk),
      .i_rst  (rst),
      .io_bus (bus)
   );

   mem_responder #(
      .TIMEOUT (4)
   ) u_dut_to (
      .i_clk  (clk),
      .i_rst  (rst),
      .io_bus (bus2)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] init_word(input int i);
      return (i == 32'h40) ? 32'h1234_5678 : {16'hC0DE, 8'h00, 8'(i)};
   endfunction

   function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                         input logic [3:0] be);
      logic [31:0] r;
      r = old;
      for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = wd[8*b +: 8];
      return r;
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // SRAM model for the main DUT: acks after ack_delay wait cycles
   assign bus.sram_ack   = bus.sram_req && (r_wait >= ack_delay);
   assign bus.sram_rdata = mem[bus.sram_addr[7:0]];
   assign bus2.sram_ack   = 1'b0;
   assign bus2.sram_rdata = 32'h0;

   always @(posedge clk) begin
      if (bus.sram_req && !bus.sram_ack) r_wait <= r_wait + 1;
      else r_wait <= 0;
      if (mem_load) begin
         for (int i = 0; i < 256; i++) mem[i] <= init_word(i);
      end else if (bus.sram_req && bus.sram_ack && bus.sram_we != 4'b0000) begin
         mem[bus.sram_addr[7:0]] <= merge(mem[bus.sram_addr[7:0]], bus.sram_wdata, bus.sram_we);
      end
   end

   always @(negedge clk) begin
      if (bus.resp_valid) begin
         exp_t e;
         resp_pulses++;
         check("resp_expected", 64'(sb_q.size() != 0), 64'd1);
         if (sb_q.size() != 0) begin
            e = sb_q.pop_front();
            check("resp_rdata", bus.resp_rdata, {e.r1, e.r0});
            check("resp_err", 64'(bus.resp_err), 64'(e.err));
         end
      end
      if (bus.sram_req && bus.sram_ack) acc_q.push_back({bus.sram_we, bus.sram_addr});
   end

   task automatic run_vec(input vec_t v, input string nm);
      exp_t        e;
      logic [33:0] exp_acc [$];
      int          lat;
      int          bad_stall;
      int          pulses0;
      int          n_lanes;
      bit          got;
      ack_delay = v.delay;
      acc_q.delete();
      pulses0 = resp_pulses;
      bus.req_valid = v.valid;
      bus.req_we    = v.we;
      bus.req_addr  = {v.addr1, v.addr0};
      bus.req_wdata = {v.wdata1, v.wdata0};
      bus.req_be    = {v.be1, v.be0};
      #1;
      check({nm, "_accept_stall"}, 64'(bus.stall), 64'd1);
      e.r0 = v.exp_r0;
      e.r1 = v.exp_r1;
      e.err = v.exp_err;
      sb_q.push_back(e);
      n_lanes = int'(v.valid[0]) + int'(v.valid[1]);
      if (v.valid[0]) exp_acc.push_back({v.we[0] ? v.be0 : 4'b0000, v.addr0[31:2]});
      if (v.valid[1]) exp_acc.push_back({v.we[1] ? v.be1 : 4'b0000, v.addr1[31:2]});
      lat = 0;
      bad_stall = 0;
      got = 1'b0;
      for (int c = 0; c < 200 && !got; c++) begin
         step();
         lat++;
         if (c == 0) begin
            // Latched fields must be used from here on, not the live inputs
            bus.req_addr  = {32'hFFFF_FFF0, 32'hFFFF_FFF0};
            bus.req_wdata = ~{v.wdata1, v.wdata0};
            bus.req_be    = 8'h00;
         end
         if (bus.resp_valid) begin
            got = 1'b1;
            check({nm, "_resp_stall"}, 64'(bus.stall), 64'd0);
            bus.req_valid = 2'b00;
         end else if (!bus.stall) begin
            bad_stall++;
         end
      end
      check({nm, "_latency"}, 64'(lat), 64'(1 + n_lanes * (v.delay + 1)));
      check({nm, "_stall_held"}, 64'(bad_stall), 64'd0);
      step();
      check({nm, "_pulses"}, 64'(resp_pulses - pulses0), 64'd1);
      check({nm, "_n_access"}, 64'(acc_q.size()), 64'(exp_acc.size()));
      for (int k = 0; k < exp_acc.size() && k < acc_q.size(); k++)
         check({nm, "_access"}, 64'(acc_q[k]), 64'(exp_acc[k]));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int pulses0;
      int lat;
      int bad_stall;
      bit got;

      vecs[0] = '{2'b01, 2'b00, 32'h100, 32'h0, 32'h0, 32'h0, 4'h0, 4'h0, 1,
                  32'h1234_5678, 32'h0, 2'b00};
      vecs[1] = '{2'b11, 2'b01, 32'h200, 32'h200, 32'hAABB_CCDD, 32'h0, 4'b0011, 4'h0, 0,
                  32'h0, 32'hC0DE_CCDD, 2'b00};
      vecs[2] = '{2'b10, 2'b00, 32'h0, 32'h30, 32'h0, 32'h0, 4'h0, 4'h0, 5,
                  32'h0, 32'hC0DE_000C, 2'b00};
      vecs[3] = '{2'b11, 2'b00, 32'h10, 32'h14, 32'h0, 32'h0, 4'h0, 4'h0, 2,
                  32'hC0DE_0004, 32'hC0DE_0005, 2'b00};
      vecs[4] = '{2'b11, 2'b11, 32'h40, 32'h44, 32'h1122_3344, 32'h5566_7788, 4'b1111,
                  4'b1100, 1, 32'h0, 32'h0, 2'b00};
      vecs[5] = '{2'b11, 2'b00, 32'h40, 32'h44, 32'h0, 32'h0, 4'h0, 4'h0, 0,
                  32'h1122_3344, 32'h5566_0011, 2'b00};
      vecs[6] = '{2'b01, 2'b00, 32'h103, 32'h0, 32'h0, 32'h0, 4'h0, 4'h0, 3,
                  32'h1234_5678, 32'h0, 2'b00};
      vecs[7] = '{2'b10, 2'b10, 32'h0, 32'h8, 32'h0, 32'hFFFF_0000, 4'h0, 4'b1000, 0,
                  32'h0, 32'h0, 2'b00};

      bus.req_valid = '0;  bus.req_we = '0;  bus.req_addr = '0;
      bus.req_wdata = '0;  bus.req_be = '0;
      bus2.req_valid = '0; bus2.req_we = '0; bus2.req_addr = '0;
      bus2.req_wdata = '0; bus2.req_be = '0;

      repeat (3) step();
      check("rst_stall", 64'(bus.stall), 64'd0);
      check("rst_resp_valid", 64'(bus.resp_valid), 64'd0);
      check("rst_sram_req", 64'(bus.sram_req), 64'd0);
      check("rst_sram_we", 64'(bus.sram_we), 64'd0);
      check("rst_resp_err", 64'(bus.resp_err), 64'd0);
      check("rst_resp_rdata", bus.resp_rdata, 64'd0);
      rst = 1'b0;
      mem_load = 1'b0;
      step();
      check("idle_stall", 64'(bus.stall), 64'd0);

      for (int i = 0; i < 8; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

      // Reset while lane 1 is being accessed abandons the batch
      ack_delay = 3;
      acc_q.delete();
      pulses0 = resp_pulses;
      bus.req_valid = 2'b11;
      bus.req_we    = 2'b00;
      bus.req_addr  = {32'h14, 32'h10};
      repeat (6) step();
      check("rstacc_in_acc1", 64'(bus.sram_addr), 64'(30'h5));
      rst = 1'b1;
      bus.req_valid = 2'b00;
      step();
      check("rstacc_stall", 64'(bus.stall), 64'd0);
      check("rstacc_sram_req", 64'(bus.sram_req), 64'd0);
      check("rstacc_sram_we", 64'(bus.sram_we), 64'd0);
      check("rstacc_resp_valid", 64'(bus.resp_valid), 64'd0);
      check("rstacc_rdata_clr", bus.resp_rdata, 64'd0);
      rst = 1'b0;
      repeat (3) step();
      check("rstacc_no_resp", 64'(resp_pulses - pulses0), 64'd0);
      run_vec(vecs[3], "post_rst");

      // Request held through RESP is taken only in the following IDLE cycle
      ack_delay = 0;
      pulses0 = resp_pulses;
      bus.req_valid = 2'b01;
      bus.req_we    = 2'b00;
      bus.req_addr  = {32'h0, 32'h100};
      #1;
      check("b2b_accept1", 64'(bus.stall), 64'd1);
      sb_q.push_back('{32'h1234_5678, 32'h0, 2'b00});
      sb_q.push_back('{32'h1234_5678, 32'h0, 2'b00});
      step();
      step();
      check("b2b_resp1", 64'(bus.resp_valid), 64'd1);
      check("b2b_resp1_stall", 64'(bus.stall), 64'd0);
      step();
      check("b2b_idle_no_resp", 64'(bus.resp_valid), 64'd0);
      check("b2b_accept2", 64'(bus.stall), 64'd1);
      step();
      check("b2b_acc_no_resp", 64'(bus.resp_valid), 64'd0);
      step();
      check("b2b_resp2", 64'(bus.resp_valid), 64'd1);
      bus.req_valid = 2'b00;
      step();
      check("b2b_pulses", 64'(resp_pulses - pulses0), 64'd2);

      // SRAM that never acks, TIMEOUT=4
      bus2.req_valid = 2'b01;
      bus2.req_we    = 2'b00;
      bus2.req_addr  = {32'h0, 32'h100};
      #1;
      check("to_accept", 64'(bus2.stall), 64'd1);
      lat = 0;
      bad_stall = 0;
      got = 1'b0;
      for (int c = 0; c < 50 && !got; c++) begin
         step();
         lat++;
         if (c == 0) check("to_sram_addr", 64'(bus2.sram_addr), 64'h40);
         if (bus2.resp_valid) begin
            got = 1'b1;
            check("to_err", 64'(bus2.resp_err), 64'b01);
            check("to_rdata", bus2.resp_rdata, {32'h0, 32'hDEAD_BEEF});
            bus2.req_valid = 2'b00;
         end else if (!bus2.stall) begin
            bad_stall++;
         end
      end
      check("to_latency", 64'(lat), 64'd6);
      check("to_stall_held", 64'(bad_stall), 64'd0);
      step();
      check("to_idle", 64'(bus2.sram_req), 64'd0);

      check("scoreboard_drained", 64'(sb_q.size()), 64'd0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
